// File: rtl/regfile_rename.sv
// regfile_rename
//   Architectural register file with per-register rename state. Each
//   register holds a value, a busy bit and the ROB tag of its in-flight
//   producer. Register 0 is hardwired to zero.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   flush            drop all rename state (busy/tag) at the next edge
//   issue_*          dispatch renames issue_rd to ROB entry issue_tag
//   commit_*         ROB writes commit_data to commit_rd, releases rename
//                    state when commit_tag matches the current producer
//   rs1_*, rs2_*     combinational read ports (data, busy, producer tag)
module regfile_rename #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int TAG_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [TAG_W-1:0]  issue_tag,
   input  logic              commit_en,
   input  logic [ADDR_W-1:0] commit_rd,
   input  logic [TAG_W-1:0]  commit_tag,
   input  logic [XLEN-1:0]   commit_data,
   input  logic              rs1_en,
   input  logic [ADDR_W-1:0] rs1_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic              rs1_busy,
   output logic [TAG_W-1:0]  rs1_tag,
   input  logic              rs2_en,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs2_data,
   output logic              rs2_busy,
   output logic [TAG_W-1:0]  rs2_tag
);

   logic [NUM_REGS-1:0][XLEN-1:0]  val_q,  val_d;
   logic [NUM_REGS-1:0]            busy_q, busy_d;
   logic [NUM_REGS-1:0][TAG_W-1:0] tag_q,  tag_d;

   // Next-state: commit first, then flush/issue so that a same-cycle issue
   // to the committing register keeps it renamed to the newer producer.
   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (commit_en && commit_rd == ADDR_W'(r)) begin
            val_d[r] = commit_data;
            // Only the current producer may release the rename.
            if (busy_q[r] && tag_q[r] == commit_tag) begin
               busy_d[r] = 1'b0;
               tag_d[r]  = '0;
            end
         end
         if (flush) begin
            busy_d[r] = 1'b0;
            tag_d[r]  = '0;
         end else if (issue_en && issue_rd == ADDR_W'(r)) begin
            busy_d[r] = 1'b1;
            tag_d[r]  = issue_tag;
         end
      end
      val_d[0]  = '0;
      busy_d[0] = 1'b0;
      tag_d[0]  = '0;
      if (rst) begin
         val_d  = '0;
         busy_d = '0;
         tag_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
   end

   // Read ports share one body; index 0 is rs1, index 1 is rs2.
   logic [1:0]                 p_en;
   logic [1:0][ADDR_W-1:0]     p_addr;
   logic [1:0][XLEN-1:0]       p_data;
   logic [1:0]                 p_busy;
   logic [1:0][TAG_W-1:0]      p_tag;

   assign p_en   = {rs2_en, rs1_en};
   assign p_addr = {rs2_addr, rs1_addr};

   // Reads see state from before this cycle's issue, so a dispatching
   // instruction never observes its own destination rename. A matching
   // commit is forwarded so the consumer does not wait a cycle for it.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         p_data[p] = '0;
         p_busy[p] = 1'b0;
         p_tag[p]  = '0;
         if (!rst && p_en[p] && p_addr[p] != '0 && int'(p_addr[p]) < NUM_REGS) begin
            if (commit_en && commit_rd == p_addr[p] &&
                busy_q[p_addr[p]] && tag_q[p_addr[p]] == commit_tag) begin
               p_data[p] = commit_data;
            end else begin
               p_data[p] = val_q[p_addr[p]];
               p_busy[p] = busy_q[p_addr[p]];
               p_tag[p]  = busy_q[p_addr[p]] ? tag_q[p_addr[p]] : '0;
            end
         end
      end
   end

   assign rs1_data = p_data[0];
   assign rs1_busy = p_busy[0];
   assign rs1_tag  = p_tag[0];
   assign rs2_data = p_data[1];
   assign rs2_busy = p_busy[1];
   assign rs2_tag  = p_tag[1];

endmodule

// File: tb/tb_regfile_rename.sv
// Testbench for regfile_rename: directed table of cycles with hand-computed
// expected read results, then randomized traffic against a register-array
// reference model.
module tb_regfile_rename;

   logic        clk;
   logic        rst, flush;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_tag;
   logic        commit_en;
   logic [4:0]  commit_rd;
   logic [3:0]  commit_tag;
   logic [31:0] commit_data;
   logic        rs1_en, rs2_en;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic [3:0]  rs1_tag, rs2_tag;

   regfile_rename dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_data(commit_data),
      .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
      .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
      .rs2_en(rs2_en), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
      .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus plus the expected same-cycle read results.
   typedef struct {
      int rst, fl;
      int ie, ird, itag;
      int ce, crd, ctag, cd;
      int r1e, r1a, r2e, r2a;
      int e1d, e1b, e1t;
      int e2d, e2b, e2t;
   } vec_t;

   vec_t tbl[23];

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: plain per-register arrays.
   logic [31:0] m_val  [32];
   bit          m_busy [32];
   logic [3:0]  m_tag  [32];

   function automatic logic [36:0] mread(input logic en, input logic [4:0] a);
      if (rst || !en || a == 5'd0) return '0;
      if (commit_en && commit_rd == a && m_busy[a] && m_tag[a] == commit_tag)
         return {commit_data, 1'b0, 4'h0};
      return {m_val[a], m_busy[a], m_busy[a] ? m_tag[a] : 4'h0};
   endfunction

   task automatic mupdate();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
         end
      end else begin
         if (commit_en && commit_rd != 0) begin
            m_val[commit_rd] = commit_data;
            if (m_busy[commit_rd] && m_tag[commit_rd] == commit_tag)
               m_busy[commit_rd] = 0;
         end
         if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
         end else if (issue_en && issue_rd != 0) begin
            m_busy[issue_rd] = 1;
            m_tag[issue_rd]  = issue_tag;
         end
      end
   endtask

   task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                    name, act[36:5], act[4], act[3:0], exp[36:5], exp[4], exp[3:0]);
   endtask

   // Drive a cycle from a negedge, check reads, then advance the model.
   task automatic apply(input vec_t v, input bit use_tbl, input string name);
      logic [36:0] e1, e2;
      rst         = v.rst[0];
      flush       = v.fl[0];
      issue_en    = v.ie[0];
      issue_rd    = 5'(v.ird);
      issue_tag   = 4'(v.itag);
      commit_en   = v.ce[0];
      commit_rd   = 5'(v.crd);
      commit_tag  = 4'(v.ctag);
      commit_data = 32'(v.cd);
      rs1_en      = v.r1e[0];
      rs1_addr    = 5'(v.r1a);
      rs2_en      = v.r2e[0];
      rs2_addr    = 5'(v.r2a);
      #1;
      if (use_tbl) begin
         e1 = {32'(v.e1d), v.e1b[0], 4'(v.e1t)};
         e2 = {32'(v.e2d), v.e2b[0], 4'(v.e2t)};
      end else begin
         e1 = mread(rs1_en, rs1_addr);
         e2 = mread(rs2_en, rs2_addr);
      end
      chk({name, "/rs1"}, {rs1_data, rs1_busy, rs1_tag}, e1);
      chk({name, "/rs2"}, {rs2_data, rs2_busy, rs2_tag}, e2);
      @(posedge clk);
      mupdate();
      @(negedge clk);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; flush = 0; issue_en = 0; issue_rd = 0; issue_tag = 0;
      commit_en = 0; commit_rd = 0; commit_tag = 0; commit_data = 0;
      rs1_en = 0; rs1_addr = 0; rs2_en = 0; rs2_addr = 0;

      //         rst fl  ie ird itag  ce crd ctag cd            r1e r1a r2e r2a  e1d          e1b e1t  e2d          e2b e2t
      tbl[0]  = '{1, 0,  0, 0, 0,     0, 0, 0, 0,               1, 5, 1, 5,      0, 0, 0,               0, 0, 0};
      tbl[1]  = '{0, 0,  0, 0, 0,     1, 5, 3, 32'hDEADBEEF,    1, 5, 1, 5,      0, 0, 0,               0, 0, 0};
      tbl[2]  = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 5, 1, 5,      32'hDEADBEEF, 0, 0,    32'hDEADBEEF, 0, 0};
      tbl[3]  = '{0, 0,  1, 7, 2,     0, 0, 0, 0,               1, 7, 1, 5,      0, 0, 0,               32'hDEADBEEF, 0, 0};
      tbl[4]  = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 7, 0, 7,      0, 1, 2,               0, 0, 0};
      tbl[5]  = '{0, 0,  0, 0, 0,     1, 7, 2, 32'h1234,        1, 7, 1, 7,      32'h1234, 0, 0,        32'h1234, 0, 0};
      tbl[6]  = '{0, 0,  1, 7, 2,     0, 0, 0, 0,               1, 7, 1, 7,      32'h1234, 0, 0,        32'h1234, 0, 0};
      tbl[7]  = '{0, 0,  1, 7, 5,     0, 0, 0, 0,               1, 7, 0, 0,      32'h1234, 1, 2,        0, 0, 0};
      tbl[8]  = '{0, 0,  0, 0, 0,     1, 7, 2, 32'hAA,          1, 7, 1, 0,      32'h1234, 1, 5,        0, 0, 0};
      tbl[9]  = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 7, 1, 7,      32'hAA, 1, 5,          32'hAA, 1, 5};
      tbl[10] = '{0, 0,  0, 0, 0,     1, 7, 5, 32'hBB,          1, 7, 0, 7,      32'hBB, 0, 0,          0, 0, 0};
      tbl[11] = '{0, 0,  1, 9, 1,     0, 0, 0, 0,               1, 7, 1, 9,      32'hBB, 0, 0,          0, 0, 0};
      tbl[12] = '{0, 0,  1, 9, 6,     1, 9, 1, 32'h55,          1, 9, 1, 9,      32'h55, 0, 0,          32'h55, 0, 0};
      tbl[13] = '{0, 0,  1, 3, 4,     0, 0, 0, 0,               1, 9, 1, 7,      32'h55, 1, 6,          32'hBB, 0, 0};
      tbl[14] = '{0, 0,  1, 4, 8,     0, 0, 0, 0,               1, 3, 0, 0,      0, 1, 4,               0, 0, 0};
      tbl[15] = '{0, 1,  1, 10, 9,    1, 9, 6, 32'h77,          1, 4, 1, 3,      0, 1, 8,               0, 1, 4};
      tbl[16] = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 10, 1, 4,     0, 0, 0,               0, 0, 0};
      tbl[17] = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 3, 1, 9,      0, 0, 0,               32'h77, 0, 0};
      tbl[18] = '{0, 0,  1, 0, 1,     1, 0, 0, 32'hFFFF,        1, 0, 1, 0,      0, 0, 0,               0, 0, 0};
      tbl[19] = '{0, 0,  1, 7, 3,     0, 0, 0, 0,               1, 0, 1, 0,      0, 0, 0,               0, 0, 0};
      tbl[20] = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 7, 1, 7,      32'hBB, 1, 3,          32'hBB, 1, 3};
      tbl[21] = '{1, 0,  1, 8, 2,     1, 7, 3, 32'h99,          1, 7, 1, 7,      0, 0, 0,               0, 0, 0};
      tbl[22] = '{0, 0,  0, 0, 0,     0, 0, 0, 0,               1, 7, 1, 8,      0, 0, 0,               0, 0, 0};

      @(negedge clk);
      for (int i = 0; i < 23; i++) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Randomized traffic on a small address window to force collisions.
      for (int c = 0; c < 800; c++) begin
         v.rst  = ($urandom_range(0, 59) == 0) ? 1 : 0;
         v.fl   = ($urandom_range(0, 19) == 0) ? 1 : 0;
         v.ie   = int'($urandom_range(0, 1));
         v.ird  = int'($urandom_range(0, 9));
         v.itag = int'($urandom_range(0, 15));
         v.ce   = int'($urandom_range(0, 1));
         v.crd  = int'($urandom_range(0, 9));
         v.ctag = ($urandom_range(0, 1) == 1) ? int'(m_tag[v.crd]) : int'($urandom_range(0, 15));
         v.cd   = int'($urandom);
         v.r1e  = ($urandom_range(0, 7) != 0) ? 1 : 0;
         v.r1a  = ($urandom_range(0, 1) == 1) ? v.crd : int'($urandom_range(0, 31));
         v.r2e  = ($urandom_range(0, 7) != 0) ? 1 : 0;
         v.r2a  = int'($urandom_range(0, 9));
         v.e1d = 0; v.e1b = 0; v.e1t = 0; v.e2d = 0; v.e2b = 0; v.e2t = 0;
         apply(v, 1'b0, $sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
